// File: rtl/i2c_reg_slave.sv
// I2C register target: synchronised SCL/SDA, START/STOP decode, byte-wide register port.
// Latency: reg_wr_en SYNC_STAGES+1 clk after the 8th SCL rise; reg_rd_en on the SCL fall that starts a read byte.
// Backpressure: none, the target never stretches SCL; sda is open-drain (0 or Z only).
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h40,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_ACK_ADDR,
    S_REG_PTR,
    S_ACK_PTR,
    S_WR_DATA,
    S_ACK_WR,
    S_RD_DATA,
    S_RD_ACK
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   rw_q, rw_d;
  logic                   busy_q, busy_d;
  logic [7:0]             reg_addr_q, reg_addr_d;
  logic [7:0]             reg_wdata_q, reg_wdata_d;
  logic                   reg_wr_en_q, reg_wr_en_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic       rx_last;
  logic [7:0] byte_in;
  logic       rd_load;

  // Open-drain pad: only ever pull low or release; reset releases it asynchronously.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = rd_load;
  assign busy      = busy_q;

  // Synchroniser shift and one-clk-delayed copies for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise   = scl_s & ~scl_prev_q;
    scl_fall   = ~scl_s & scl_prev_q;
    // SDA edges with SCL high are bus conditions, never data.
    start_det  = scl_s & sda_prev_q & ~sda_s;
    stop_det   = scl_s & ~sda_prev_q & sda_s;
    byte_in    = {shift_q[6:0], sda_s};
    rx_last    = scl_rise && (bit_cnt_q == 4'd7);
  end

  // Protocol FSM: START/STOP override everything, otherwise bit-level work per state.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    rd_load     = 1'b0;

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      // A START mid-byte simply discards whatever was shifted so far.
      state_d   = S_DEV_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: ;

        S_DEV_ADDR, S_REG_PTR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (rx_last) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              S_DEV_ADDR: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = S_ACK_ADDR;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end
              end
              S_REG_PTR: begin
                reg_addr_d = byte_in;
                state_d    = S_ACK_PTR;
              end
              default: begin
                reg_wdata_d = byte_in;
                reg_wr_en_d = 1'b1;
                state_d     = S_ACK_WR;
              end
            endcase
          end
        end

        // First SCL fall pulls the ACK low, the second releases it and moves on.
        S_ACK_ADDR, S_ACK_PTR, S_ACK_WR: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              case (state_q)
                S_ACK_ADDR: begin
                  if (rw_q) begin
                    rd_load  = 1'b1;
                    shift_d  = {reg_rdata[6:0], 1'b0};
                    sda_oe_d = ~reg_rdata[7];
                    state_d  = S_RD_DATA;
                  end else begin
                    state_d = S_REG_PTR;
                  end
                end
                S_ACK_PTR: state_d = S_WR_DATA;
                default: begin
                  reg_addr_d = reg_addr_q + 8'd1;
                  state_d    = S_WR_DATA;
                end
              endcase
            end
          end
        end

        // shift_q[7] always holds the next bit to present on the following SCL fall.
        S_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end

        // bit_cnt_q==1 marks that the controller ACKed and another byte is wanted.
        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
            rd_load   = 1'b1;
            shift_d   = {reg_rdata[6:0], 1'b0};
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; synchronisers reset to the idle-high bus level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_wr_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C controller plus a register-file model on the read port.
// Expected write strobes, read strobes and read bytes are queued as stimulus is issued.
// A monitor pops the queues whenever the target strobes its register port.
module tb_i2c_reg_slave;

  localparam int H = 5;  // half of one SCL phase, in clk cycles

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] dat;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_oe;
  wire        sda;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic       busy;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         dut_low_cnt  = 0;
  wr_t        wr_q[$];
  logic [7:0] rd_addr_q[$];
  logic [7:0] rd_dat_q[$];
  wr_t        mon_e;
  logic [7:0] mon_a;

  always #5 clk = ~clk;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  // Register-file model: read data is a fixed function of the pointer.
  assign reg_rdata = reg_addr ^ 8'hA5;

  i2c_reg_slave #(.DEV_ADDR(7'h40), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && reg_wr_en) begin
      chk("wr_strobe_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        mon_e = wr_q.pop_front();
        chk("wr_addr", 32'(reg_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(reg_wdata), 32'(mon_e.dat));
      end
    end
    if (reset && reg_rd_en) begin
      chk("rd_strobe_expected", 32'(rd_addr_q.size() != 0), 32'd1);
      if (rd_addr_q.size() != 0) begin
        mon_a = rd_addr_q.pop_front();
        chk("rd_addr", 32'(reg_addr), 32'(mon_a));
      end
    end
    // Bus low while the controller is released means the target is pulling it.
    if (reset && !m_oe && (sda === 1'b0)) dut_low_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: b=1 releases SDA, b=0 pulls it low; rx is the bus sampled mid-high.
  task automatic bit_cycle(input logic b, output logic rx);
    wait_clks(H);
    m_oe = ~b;
    wait_clks(H);
    scl = 1'b1;
    wait_clks(H);
    rx = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_clks(H);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clks(H);
    m_oe = 1'b0;
    wait_clks(H);
    scl = 1'b1;
    wait_clks(H);
    m_oe = 1'b1;
    wait_clks(H);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(H);
    m_oe = 1'b1;
    wait_clks(H);
    scl = 1'b1;
    wait_clks(H);
    m_oe = 1'b0;
    wait_clks(2 * H);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic rx;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], rx);
    bit_cycle(1'b1, rx);
    ack = ~rx;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic rx;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, rx);
      d = {d[6:0], rx};
    end
    bit_cycle(~ack, rx);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] dat, input string tag);
    logic ack;
    i2c_start();
    send_byte(8'h80, ack);
    chk({tag, "_ack_addr"}, 32'(ack), 32'd1);
    send_byte(ptr, ack);
    chk({tag, "_ack_ptr"}, 32'(ack), 32'd1);
    wr_q.push_back('{addr: ptr, dat: dat});
    send_byte(dat, ack);
    chk({tag, "_ack_data"}, 32'(ack), 32'd1);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic       rx;
    logic [7:0] d;
    int         low_before;

    reset = 1'b0;
    scl   = 1'b1;
    m_oe  = 1'b0;
    wait_clks(5);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sda_released", 32'(sda === 1'b0), 32'd0);
    reset = 1'b1;
    wait_clks(5);

    // 1: single register write of 0x00 to 0x1D.
    i2c_start();
    send_byte(8'h80, ack);
    chk("t1_ack_addr", 32'(ack), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h1D, ack);
    chk("t1_ack_ptr", 32'(ack), 32'd1);
    wr_q.push_back('{addr: 8'h1D, dat: 8'h00});
    send_byte(8'h00, ack);
    chk("t1_ack_data", 32'(ack), 32'd1);
    i2c_stop();
    chk("t1_busy_after_stop", 32'(busy), 32'd0);

    // 2: burst write with pointer auto-increment.
    i2c_start();
    send_byte(8'h80, ack);
    chk("t2_ack_addr", 32'(ack), 32'd1);
    send_byte(8'h02, ack);
    chk("t2_ack_ptr", 32'(ack), 32'd1);
    wr_q.push_back('{addr: 8'h02, dat: 8'h01});
    send_byte(8'h01, ack);
    chk("t2_ack_d0", 32'(ack), 32'd1);
    wr_q.push_back('{addr: 8'h03, dat: 8'h03});
    send_byte(8'h03, ack);
    chk("t2_ack_d1", 32'(ack), 32'd1);
    i2c_stop();
    chk("t2_reg_addr", 32'(reg_addr), 32'h04);

    // 3: wrong device address, target must stay off the bus.
    low_before = dut_low_cnt;
    i2c_start();
    send_byte(8'h82, ack);
    chk("t3_nack_addr", 32'(ack), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    send_byte(8'h05, ack);
    chk("t3_nack_b1", 32'(ack), 32'd0);
    send_byte(8'h06, ack);
    chk("t3_nack_b2", 32'(ack), 32'd0);
    i2c_stop();
    chk("t3_sda_never_driven", 32'(dut_low_cnt - low_before), 32'd0);
    chk("t3_reg_addr_kept", 32'(reg_addr), 32'h04);

    // 4: pointer write, repeated START, two-byte read ending in NACK.
    i2c_start();
    send_byte(8'h80, ack);
    chk("t4_ack_addr_w", 32'(ack), 32'd1);
    send_byte(8'h10, ack);
    chk("t4_ack_ptr", 32'(ack), 32'd1);
    i2c_start();
    rd_addr_q.push_back(8'h10);
    rd_addr_q.push_back(8'h11);
    rd_dat_q.push_back(8'h10 ^ 8'hA5);
    rd_dat_q.push_back(8'h11 ^ 8'hA5);
    send_byte(8'h81, ack);
    chk("t4_ack_addr_r", 32'(ack), 32'd1);
    recv_byte(1'b1, d);
    chk("t4_rd_byte0", 32'(d), 32'(rd_dat_q.pop_front()));
    recv_byte(1'b0, d);
    chk("t4_rd_byte1", 32'(d), 32'(rd_dat_q.pop_front()));
    chk("t4_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    chk("t4_reg_addr", 32'(reg_addr), 32'h11);

    // 5: STOP after five data bits discards the partial byte.
    i2c_start();
    send_byte(8'h80, ack);
    chk("t5_ack_addr", 32'(ack), 32'd1);
    send_byte(8'h20, ack);
    chk("t5_ack_ptr", 32'(ack), 32'd1);
    for (int i = 0; i < 5; i++) bit_cycle(i[0], rx);
    i2c_stop();
    chk("t5_busy_idle", 32'(busy), 32'd0);
    chk("t5_reg_addr", 32'(reg_addr), 32'h20);
    wr_txn(8'h21, 8'h77, "t5_next");
    chk("t5_reg_addr_after", 32'(reg_addr), 32'h22);

    // 6: reset while the target holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(i == 7, rx);
    wait_clks(H);
    m_oe = 1'b0;
    wait_clks(2);
    chk("t6_ack_held_low", 32'(sda === 1'b0), 32'd1);
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_sda_released", 32'(sda === 1'b0), 32'd0);
    chk("t6_reg_addr", 32'(reg_addr), 32'd0);
    chk("t6_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("t6_wr_en", 32'(reg_wr_en), 32'd0);
    chk("t6_rd_en", 32'(reg_rd_en), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    wait_clks(3);
    scl = 1'b1;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(10);

    // Recovery after reset.
    wr_txn(8'h05, 8'hC3, "t6_recover");
    chk("t6_recover_reg_addr", 32'(reg_addr), 32'h06);

    wait_clks(10);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
